// File: rtl/elastic_config_loader_pkg.sv
// Shared widths, FSM state and config-record type for the elastic config loader.
package elastic_config_loader_pkg;

  localparam int unsigned PE_NUM                     = 16;
  localparam int unsigned PE_ID_BIT_LENGTH           = 4;
  localparam int unsigned CONTEXT_SIZE               = 16;
  localparam int unsigned CONTEXT_SIZE_BIT_LENGTH    = 4;
  localparam int unsigned NEIGHBOR_PE_NUM            = 4;
  localparam int unsigned NEIGHBOR_PE_NUM_BIT_LENGTH = 2;
  localparam int unsigned OPERATION_BIT_LENGTH       = 4;
  localparam int unsigned DATA_WIDTH                 = 32;
  localparam int unsigned COUNT_WIDTH                = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    START = 2'd2,
    RUN   = 2'd3
  } state_t;

  // Mirrors the per-PE config memory word broadcast on the config bus.
  typedef struct packed {
    logic [NEIGHBOR_PE_NUM_BIT_LENGTH-1:0] input_pe_index_1;
    logic [NEIGHBOR_PE_NUM_BIT_LENGTH-1:0] input_pe_index_2;
    logic [NEIGHBOR_PE_NUM-1:0]            output_pe_index;
    logic [OPERATION_BIT_LENGTH-1:0]       op;
    logic [DATA_WIDTH-1:0]                 const_data;
    logic [CONTEXT_SIZE_BIT_LENGTH-1:0]    context_index;
  } cfg_rec_t;

endpackage

// File: rtl/elastic_config_loader_if.sv
// Self-handshaked configuration record stream into the loader.
interface elastic_config_loader_if
  import elastic_config_loader_pkg::*;
  ();

  logic                                  cfg_valid_input;
  logic                                  cfg_stop_input;
  logic [PE_ID_BIT_LENGTH-1:0]           cfg_pe_id;
  logic [CONTEXT_SIZE_BIT_LENGTH-1:0]    cfg_context_index;
  logic [NEIGHBOR_PE_NUM_BIT_LENGTH-1:0] cfg_input_PE_index_1;
  logic [NEIGHBOR_PE_NUM_BIT_LENGTH-1:0] cfg_input_PE_index_2;
  logic [NEIGHBOR_PE_NUM-1:0]            cfg_output_PE_index;
  logic [OPERATION_BIT_LENGTH-1:0]       cfg_op;
  logic [DATA_WIDTH-1:0]                 cfg_const_data;
  logic                                  cfg_last;

  modport master (
    output cfg_valid_input, cfg_pe_id, cfg_context_index, cfg_input_PE_index_1,
           cfg_input_PE_index_2, cfg_output_PE_index, cfg_op, cfg_const_data, cfg_last,
    input  cfg_stop_input
  );

  modport slave (
    input  cfg_valid_input, cfg_pe_id, cfg_context_index, cfg_input_PE_index_1,
           cfg_input_PE_index_2, cfg_output_PE_index, cfg_op, cfg_const_data, cfg_last,
    output cfg_stop_input
  );

endinterface

// File: rtl/elastic_config_loader_decoder.sv
// Combinational record decode: PE id to one-hot strobe plus PE/context range checks.
module elastic_config_decoder
  import elastic_config_loader_pkg::*;
(
  input  logic [PE_ID_BIT_LENGTH-1:0]        pe_id,
  input  logic [CONTEXT_SIZE_BIT_LENGTH-1:0] context_index,
  input  logic [CONTEXT_SIZE_BIT_LENGTH-1:0] max_id,
  output logic [PE_NUM-1:0]                  pe_onehot_c,
  output logic                               record_ok_c
);

  always_comb begin
    pe_onehot_c = '0;
    record_ok_c = 1'b0;
    if ((32'(pe_id) < PE_NUM) && (32'(context_index) < CONTEXT_SIZE) &&
        (context_index <= max_id)) begin
      record_ok_c        = 1'b1;
      pe_onehot_c[pe_id] = 1'b1;
    end
  end

endmodule

// File: rtl/elastic_config_loader.sv
// Sequences config load -> start -> run: writes records onto the broadcast PE config
// bus, then issues a one-cycle start_exec two cycles after the last accepted record.
module elastic_config_loader
  import elastic_config_loader_pkg::*;
(
  input  logic                                  clk,
  input  logic                                  reset_n,
  elastic_config_loader_if.slave                cfg,
  input  logic                                  load_request,
  input  logic [CONTEXT_SIZE_BIT_LENGTH-1:0]    load_context_max_id,
  output logic [NEIGHBOR_PE_NUM_BIT_LENGTH-1:0] config_input_PE_index_1,
  output logic [NEIGHBOR_PE_NUM_BIT_LENGTH-1:0] config_input_PE_index_2,
  output logic [NEIGHBOR_PE_NUM-1:0]            config_output_PE_index,
  output logic [OPERATION_BIT_LENGTH-1:0]       config_op,
  output logic [DATA_WIDTH-1:0]                 config_const_data,
  output logic [CONTEXT_SIZE_BIT_LENGTH-1:0]    config_index,
  output logic [PE_NUM-1:0]                     write_config_data,
  output logic                                  start_exec,
  output logic [CONTEXT_SIZE_BIT_LENGTH-1:0]    mapping_context_max_id,
  output logic                                  busy,
  output logic [COUNT_WIDTH-1:0]                loaded_count,
  output logic                                  config_error
);

  state_t                state, state_nxt;
  cfg_rec_t              rec_c, bus_q;
  logic                  accept_c;
  logic                  load_go_c;
  logic [PE_NUM-1:0]     pe_onehot_c;
  logic                  record_ok_c;

  assign cfg.cfg_stop_input = (state != LOAD);
  assign accept_c           = cfg.cfg_valid_input && (state == LOAD);
  // START is a single committed cycle; a reload there is not honoured.
  assign load_go_c          = load_request && (state != START);

  always_comb begin
    rec_c                  = '0;
    rec_c.input_pe_index_1 = cfg.cfg_input_PE_index_1;
    rec_c.input_pe_index_2 = cfg.cfg_input_PE_index_2;
    rec_c.output_pe_index  = cfg.cfg_output_PE_index;
    rec_c.op               = cfg.cfg_op;
    rec_c.const_data       = cfg.cfg_const_data;
    rec_c.context_index    = cfg.cfg_context_index;
  end

  elastic_config_decoder u_decoder (
    .pe_id         (cfg.cfg_pe_id),
    .context_index (cfg.cfg_context_index),
    .max_id        (mapping_context_max_id),
    .pe_onehot_c   (pe_onehot_c),
    .record_ok_c   (record_ok_c)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (load_request) state_nxt = LOAD;
      LOAD:    if (accept_c && cfg.cfg_last) state_nxt = START;
      START:   state_nxt = RUN;
      RUN:     if (load_request) state_nxt = LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Bus register, strobe, start pulse and load bookkeeping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus_q                  <= '0;
      write_config_data      <= '0;
      start_exec             <= 1'b0;
      busy                   <= 1'b0;
      mapping_context_max_id <= '0;
      loaded_count           <= '0;
      config_error           <= 1'b0;
    end else begin
      write_config_data <= (accept_c && record_ok_c) ? pe_onehot_c : '0;
      start_exec        <= (state == START);
      busy              <= (state_nxt == LOAD) || (state_nxt == START);
      if (accept_c && record_ok_c) bus_q <= rec_c;
      if (load_go_c) begin
        mapping_context_max_id <= load_context_max_id;
        loaded_count           <= '0;
        config_error           <= 1'b0;
      end else begin
        if (accept_c && record_ok_c && (loaded_count != '1))
          loaded_count <= loaded_count + COUNT_WIDTH'(1);
        if (accept_c && !record_ok_c)
          config_error <= 1'b1;
      end
    end
  end

  assign config_input_PE_index_1 = bus_q.input_pe_index_1;
  assign config_input_PE_index_2 = bus_q.input_pe_index_2;
  assign config_output_PE_index  = bus_q.output_pe_index;
  assign config_op               = bus_q.op;
  assign config_const_data       = bus_q.const_data;
  assign config_index            = bus_q.context_index;

endmodule

// File: tb/tb_elastic_config_loader.sv
// Directed bench for elastic_config_loader with a scoreboard of expected bus writes.
module tb_elastic_config_loader;
  import elastic_config_loader_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        load_request;
  logic [3:0]  load_context_max_id;
  logic [1:0]  config_input_PE_index_1, config_input_PE_index_2;
  logic [3:0]  config_output_PE_index, config_op, config_index;
  logic [31:0] config_const_data;
  logic [15:0] write_config_data;
  logic        start_exec, busy, config_error;
  logic [3:0]  mapping_context_max_id;
  logic [15:0] loaded_count;

  elastic_config_loader_if cfg_if ();

  elastic_config_loader dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .cfg                     (cfg_if),
    .load_request            (load_request),
    .load_context_max_id     (load_context_max_id),
    .config_input_PE_index_1 (config_input_PE_index_1),
    .config_input_PE_index_2 (config_input_PE_index_2),
    .config_output_PE_index  (config_output_PE_index),
    .config_op               (config_op),
    .config_const_data       (config_const_data),
    .config_index            (config_index),
    .write_config_data       (write_config_data),
    .start_exec              (start_exec),
    .mapping_context_max_id  (mapping_context_max_id),
    .busy                    (busy),
    .loaded_count            (loaded_count),
    .config_error            (config_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] strobe;
    logic [1:0]  i1, i2;
    logic [3:0]  omask, op, ctx;
    logic [31:0] cdata;
  } exp_t;

  exp_t        sb[$];
  int          n_total = 0;
  int          n_pass  = 0;
  int          n_fail  = 0;

  // Reference model of the loader's architectural state.
  state_t      m_st  = IDLE;
  logic [3:0]  m_max = 4'd0;
  logic [15:0] m_cnt = 16'd0;
  logic        m_err = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_strobe"}, 32'(write_config_data), 32'h0);
    chk({tag, "_start"},  32'(start_exec), 32'h0);
    chk({tag, "_busy"},   32'(busy), 32'h0);
    chk({tag, "_count"},  32'(loaded_count), 32'h0);
    chk({tag, "_err"},    32'(config_error), 32'h0);
    chk({tag, "_max"},    32'(mapping_context_max_id), 32'h0);
    chk({tag, "_const"},  32'(config_const_data), 32'h0);
    chk({tag, "_stop"},   32'(cfg_if.cfg_stop_input), 32'h1);
  endtask

  // One clock cycle: drive inputs, predict, advance, then check at posedge+1.
  task automatic cyc(input logic lr, input logic [3:0] lmax, input logic v,
                     input logic [3:0] pe, input logic [3:0] ctx, input logic last);
    exp_t   e;
    logic   acc, ok, lgo;
    state_t st_prev;
    load_request                = lr;
    load_context_max_id         = lmax;
    cfg_if.cfg_valid_input      = v;
    cfg_if.cfg_pe_id            = pe;
    cfg_if.cfg_context_index    = ctx;
    cfg_if.cfg_input_PE_index_1 = 2'($urandom);
    cfg_if.cfg_input_PE_index_2 = 2'($urandom);
    cfg_if.cfg_output_PE_index  = 4'($urandom);
    cfg_if.cfg_op               = 4'($urandom);
    cfg_if.cfg_const_data       = $urandom;
    cfg_if.cfg_last             = last;

    acc = v && (m_st == LOAD);
    ok  = acc && (ctx <= m_max);
    e.strobe = ok ? (16'h1 << pe) : 16'h0;
    e.i1     = cfg_if.cfg_input_PE_index_1;
    e.i2     = cfg_if.cfg_input_PE_index_2;
    e.omask  = cfg_if.cfg_output_PE_index;
    e.op     = cfg_if.cfg_op;
    e.ctx    = ctx;
    e.cdata  = cfg_if.cfg_const_data;
    sb.push_back(e);

    st_prev = m_st;
    lgo     = lr && (m_st != START);
    case (m_st)
      IDLE, RUN: if (lr) m_st = LOAD;
      LOAD:      if (acc && last) m_st = START;
      START:     m_st = RUN;
      default:   m_st = IDLE;
    endcase
    if (lgo) begin
      m_max = lmax; m_cnt = 16'd0; m_err = 1'b0;
    end else begin
      if (ok && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      if (acc && !ok) m_err = 1'b1;
    end

    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("strobe", 32'(write_config_data), 32'(e.strobe));
    if (e.strobe != 16'h0) begin
      chk("bus_i1",    32'(config_input_PE_index_1), 32'(e.i1));
      chk("bus_i2",    32'(config_input_PE_index_2), 32'(e.i2));
      chk("bus_omask", 32'(config_output_PE_index), 32'(e.omask));
      chk("bus_op",    32'(config_op), 32'(e.op));
      chk("bus_ctx",   32'(config_index), 32'(e.ctx));
      chk("bus_const", config_const_data, e.cdata);
    end
    chk("start_exec", 32'(start_exec), 32'(st_prev == START));
    chk("busy",       32'(busy), 32'((m_st == LOAD) || (m_st == START)));
    chk("stop",       32'(cfg_if.cfg_stop_input), 32'(m_st != LOAD));
    chk("count",      32'(loaded_count), 32'(m_cnt));
    chk("error",      32'(config_error), 32'(m_err));
    chk("max_id",     32'(mapping_context_max_id), 32'(m_max));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0;
    load_request = 1'b0;
    load_context_max_id = 4'd0;
    cfg_if.cfg_valid_input = 1'b1;
    cfg_if.cfg_pe_id = 4'd3;
    cfg_if.cfg_context_index = 4'd0;
    cfg_if.cfg_input_PE_index_1 = 2'd0;
    cfg_if.cfg_input_PE_index_2 = 2'd0;
    cfg_if.cfg_output_PE_index = 4'd0;
    cfg_if.cfg_op = 4'd0;
    cfg_if.cfg_const_data = 32'd0;
    cfg_if.cfg_last = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("rst");
    reset_n = 1'b1;

    // Idle ignores valid records.
    cyc(1'b0, 4'd0, 1'b1, 4'd5, 4'd0, 1'b1);
    cyc(1'b0, 4'd0, 1'b1, 4'd5, 4'd0, 1'b0);

    // Three back-to-back records, max id 2.
    cyc(1'b1, 4'd2, 1'b0, 4'd0, 4'd0, 1'b0);
    cyc(1'b0, 4'd0, 1'b1, 4'd5, 4'd0, 1'b0);
    cyc(1'b0, 4'd0, 1'b1, 4'd5, 4'd1, 1'b0);
    cyc(1'b0, 4'd0, 1'b1, 4'd9, 4'd2, 1'b1);
    idle(3);
    chk("burst_count", 32'(loaded_count), 32'd3);
    chk("burst_max",   32'(mapping_context_max_id), 32'd2);

    // Reload from RUN, records separated by a bubble; RUN ignores valid.
    cyc(1'b0, 4'd0, 1'b1, 4'd1, 4'd0, 1'b0);
    cyc(1'b1, 4'd3, 1'b0, 4'd0, 4'd0, 1'b0);
    cyc(1'b0, 4'd0, 1'b1, 4'd3, 4'd1, 1'b0);
    cyc(1'b0, 4'd0, 1'b0, 4'd7, 4'd1, 1'b1);
    cyc(1'b0, 4'd0, 1'b1, 4'd15, 4'd3, 1'b1);
    idle(3);

    // Out-of-range context sets the sticky error; following valid record still lands.
    cyc(1'b1, 4'd1, 1'b0, 4'd0, 4'd0, 1'b0);
    cyc(1'b0, 4'd0, 1'b1, 4'd7, 4'd3, 1'b0);
    cyc(1'b0, 4'd0, 1'b1, 4'd0, 4'd0, 1'b0);
    cyc(1'b0, 4'd0, 1'b1, 4'd2, 4'd2, 1'b1);
    idle(3);
    chk("err_sticky", 32'(config_error), 32'd1);

    // Reload clears error; reload inside LOAD restarts the count.
    cyc(1'b1, 4'd15, 1'b0, 4'd0, 4'd0, 1'b0);
    cyc(1'b0, 4'd0, 1'b1, 4'd1, 4'd15, 1'b0);
    cyc(1'b0, 4'd0, 1'b1, 4'd8, 4'd12, 1'b0);
    cyc(1'b1, 4'd5, 1'b0, 4'd0, 4'd0, 1'b0);
    cyc(1'b0, 4'd0, 1'b1, 4'd6, 4'd5, 1'b0);
    cyc(1'b0, 4'd0, 1'b1, 4'd11, 4'd6, 1'b1);
    idle(3);

    // Reset after one of three records: load is discarded, nothing starts later.
    cyc(1'b1, 4'd2, 1'b0, 4'd0, 4'd0, 1'b0);
    cyc(1'b0, 4'd0, 1'b1, 4'd4, 4'd0, 1'b0);
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    m_st = IDLE; m_max = 4'd0; m_cnt = 16'd0; m_err = 1'b0;
    sb.delete();
    @(posedge clk);
    #1;
    chk_reset_outputs("midrst_hold");
    reset_n = 1'b1;
    cyc(1'b0, 4'd0, 1'b1, 4'd4, 4'd1, 1'b0);
    cyc(1'b0, 4'd0, 1'b1, 4'd4, 4'd2, 1'b1);
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/elastic_config_loader.md
Name: elastic_config_loader

Overview:
- Upstream neighbour of the elastic PE array: takes a SELF-handshaked stream of configuration records and writes each one into one PE's config memory.
- Writes go over the broadcast config bus: input indices, output mask, op, const, context index and a per-PE write strobe.
- After the last record it issues a one-cycle start_exec and drives mapping_context_max_id to every PE.
- It is the single place that sequences load -> start -> run for a mapping.

Parameters:
PE_NUM, 16, number of PEs on the config bus
PE_ID_BIT_LENGTH, 4, width of PE id (clog2 PE_NUM)
CONTEXT_SIZE, 16, contexts per PE
CONTEXT_SIZE_BIT_LENGTH, 4, width of context index
NEIGHBOR_PE_NUM, 4, neighbour links per PE
NEIGHBOR_PE_NUM_BIT_LENGTH, 2, width of input-select index
OPERATION_BIT_LENGTH, 4, ALU opcode width
DATA_WIDTH, 32, const data width

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
load_request  in  1  pulse; begin (re)load, capture load_context_max_id
load_context_max_id  in  CONTEXT_SIZE_BIT_LENGTH  last valid context id for this mapping
cfg_valid_input  in  1  record valid (SELF)
cfg_stop_input  out  1  loader not accepting (SELF)
cfg_pe_id  in  PE_ID_BIT_LENGTH  target PE
cfg_context_index  in  CONTEXT_SIZE_BIT_LENGTH  target context slot
cfg_input_PE_index_1  in  NEIGHBOR_PE_NUM_BIT_LENGTH  mux A select
cfg_input_PE_index_2  in  NEIGHBOR_PE_NUM_BIT_LENGTH  mux B select
cfg_output_PE_index  in  NEIGHBOR_PE_NUM  output fork mask
cfg_op  in  OPERATION_BIT_LENGTH  opcode
cfg_const_data  in  DATA_WIDTH  constant
cfg_last  in  1  final record of mapping
config_input_PE_index_1 / config_input_PE_index_2 / config_output_PE_index / config_op / config_const_data / config_index  out  same widths  registered broadcast config bus
write_config_data  out  PE_NUM  one-hot per-PE write strobe
start_exec  out  1  one-cycle start pulse to all PEs
mapping_context_max_id  out  CONTEXT_SIZE_BIT_LENGTH  held max id
busy  out  1  state is LOAD or START
loaded_count  out  16  records written since last load_request (saturating)
config_error  out  1  sticky: a record was dropped

Behaviour:
- Reset (async): state IDLE. All outputs 0. cfg_stop_input=1. Reset mid-LOAD discards the load; no partial start_exec is issued.
- FSM IDLE -> LOAD on load_request. LOAD -> START on accepted beat with cfg_last. START -> RUN unconditionally. RUN -> LOAD on load_request. IDLE/RUN ignore cfg_valid_input.
- On load_request: capture load_context_max_id into mapping_context_max_id; clear loaded_count and config_error.
- load_request while in LOAD restarts the count and recaptures max id; state stays LOAD.
- cfg_stop_input = (state != LOAD), combinational from state. A beat is accepted when cfg_valid_input && !cfg_stop_input. There is no back-pressure inside LOAD: one beat per cycle.
- Accepted beat at cycle N, valid record: at N+1 the bus fields are registered and write_config_data[cfg_pe_id]=1 (exactly one bit); loaded_count+1.
- Invalid record (cfg_pe_id >= PE_NUM, or cfg_context_index > captured max id): no strobe at N+1, config_error set, loaded_count unchanged. If the invalid beat carries cfg_last, the FSM still advances to START.
- write_config_data is 0 in every cycle without an accepted valid beat. Bus fields hold their last value.
- start_exec: last beat accepted at N, its write at N+1, start_exec=1 at N+2 only. The last write therefore lands before start.
- mapping_context_max_id is stable from load_request until the next load_request.
- loaded_count saturates at 16'hFFFF.

Decomposition:
- Shared package: state enum (IDLE, LOAD, START, RUN), a config-record struct mirroring the PE config data fields, and the width constants listed above.
- Natural sub-module: elastic_config_decoder. It is combinational: pe_id -> one-hot plus range checks.

Test Plan:
- Reset then idle: cfg_valid_input=1 held -> cfg_stop_input=1, write_config_data=0, start_exec=0.
- load_request with max id 2; three records (PE 5 ctx 0, PE 5 ctx 1, PE 9 ctx 2 with cfg_last) on consecutive cycles N..N+2 -> strobes 0x0020, 0x0020, 0x0200 at N+1..N+3; start_exec at N+4 only; loaded_count=3; mapping_context_max_id=2.
- Bubbles: valid toggles 1,0,1(last) -> strobes track accepted beats only; start_exec two cycles after last accept.
- Error: max id 1, record ctx 3 -> no strobe, config_error=1; next valid record PE 0 ctx 0 -> strobe 0x0001.
- Reload in RUN: load_request -> state LOAD, busy=1, loaded_count=0, config_error=0, new max id latched.
- Reset asserted mid-LOAD after 1 of 3 records -> all outputs 0 immediately, no start_exec after release, stop=1.
